// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t : fetch controller states (IDLE, FETCH, BUF, DROP)
//   fetch_word_t  : {pc, pc+4, instruction} bundle carried into IF/ID
//   NOP, RESET_PC_DEFAULT, PC_INCR : fixed constants
package if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_BUF,
    ST_DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } fetch_word_t;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request bus between the fetch stage and memory.
//   o_imem_req   : fetch request, held until i_imem_ready
//   o_imem_addr  : word-aligned fetch address
//   i_imem_ready : completes the request; i_imem_rdata valid this cycle
//   i_imem_rdata : instruction word
// Modports: master (fetch stage), slave (instruction memory).
interface if_fetch_stage_if;

  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic [31:0] i_imem_rdata;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_ready,
    input  i_imem_rdata
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_ready,
    output i_imem_rdata
  );

endinterface

// File: rtl/if_fetch_stage_pc_incr.sv
// pc_incr: combinational sequential-PC adder (pc + 4, modulo 2^32).
//   pc       : current program counter
//   pc_plus4 : pc + 4, wraps silently past 32'hFFFF_FFFC
module pc_incr
  import if_pkg::*;
(
  input  logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + PC_INCR;

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage. Owns the PC, issues instruction
// memory requests, loads the IF/ID register, parks one word during a stall
// and handles branch/jump redirects against multi-cycle memory latency.
//   i_clk, i_rst_n  : clock, synchronous active-low reset
//   imem            : instruction-memory bus (master side)
//   i_stall         : hold IF/ID
//   i_redirect      : taken branch/jump, target on i_redirect_pc
//   o_pc_plus4      : current PC + 4 (feeds branch-target adder)
//   o_ifid_*        : IF/ID pipeline register
// Build option: IF_DELAY_SLOT_EN defined -> MIPS branch delay slot (the word
// completing/buffered/in flight at a redirect is kept). Undefined -> that
// word is flushed.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  if_fetch_stage_if.master   imem,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [31:0]        i_redirect_pc,
  output logic [31:0]        o_pc_plus4,
  output logic               o_ifid_valid,
  output logic [31:0]        o_ifid_pc,
  output logic [31:0]        o_ifid_pc4,
  output logic [31:0]        o_ifid_instr
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         req_q;
  fetch_word_t  wbuf;
  fetch_word_t  ifid;
  fetch_word_t  word_in;
  logic         ifid_valid;
`ifdef IF_DELAY_SLOT_EN
  logic         pend;
`endif

  pc_incr u_pc_incr (
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  assign word_in          = '{pc: pc, pc4: pc_plus4, instr: imem.i_imem_rdata};
  assign imem.o_imem_req  = req_q;
  assign imem.o_imem_addr = pc;
  assign o_pc_plus4       = pc_plus4;
  assign o_ifid_valid     = ifid_valid;
  assign o_ifid_pc        = ifid.pc;
  assign o_ifid_pc4       = ifid.pc4;
  assign o_ifid_instr     = ifid.instr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      req_q      <= 1'b0;
      target     <= '0;
      wbuf       <= '{pc: '0, pc4: '0, instr: NOP};
      ifid       <= '{pc: '0, pc4: '0, instr: NOP};
      ifid_valid <= 1'b0;
`ifdef IF_DELAY_SLOT_EN
      pend       <= 1'b0;
`endif
    end else begin
      // IF/ID becomes a bubble unless a word is delivered below; a stall
      // freezes it completely (data and valid).
      if (!i_stall) begin
        ifid_valid <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          state <= ST_FETCH;
          req_q <= 1'b1;
          if (i_redirect) begin
            pc <= i_redirect_pc;
          end
        end

`ifdef IF_DELAY_SLOT_EN
        // Delay slot: the word in flight is always delivered; a redirect
        // only chooses what pc becomes once that word completes.
        ST_FETCH: begin
          if (imem.i_imem_ready) begin
            if (i_stall) begin
              wbuf  <= word_in;
              state <= ST_BUF;
              req_q <= 1'b0;
            end else begin
              ifid       <= word_in;
              ifid_valid <= 1'b1;
            end
            pc   <= i_redirect ? i_redirect_pc : (pend ? target : pc_plus4);
            pend <= 1'b0;
          end else if (i_redirect) begin
            target <= i_redirect_pc;
            pend   <= 1'b1;
          end
        end

        ST_BUF: begin
          if (!i_stall) begin
            ifid       <= wbuf;
            ifid_valid <= 1'b1;
            state      <= ST_FETCH;
            req_q      <= 1'b1;
          end
          // pc already points past the buffered word, so retargeting here
          // leaves the buffered delay-slot word intact.
          if (i_redirect) begin
            pc <= i_redirect_pc;
          end
        end
`else
        ST_FETCH: begin
          if (i_redirect) begin
            if (imem.i_imem_ready) begin
              pc <= i_redirect_pc;
            end else begin
              // Keep the old address on the bus until memory answers.
              target <= i_redirect_pc;
              state  <= ST_DROP;
            end
          end else if (imem.i_imem_ready) begin
            pc <= pc_plus4;
            if (i_stall) begin
              wbuf  <= word_in;
              state <= ST_BUF;
              req_q <= 1'b0;
            end else begin
              ifid       <= word_in;
              ifid_valid <= 1'b1;
            end
          end
        end

        ST_BUF: begin
          if (i_redirect) begin
            pc    <= i_redirect_pc;
            state <= ST_FETCH;
            req_q <= 1'b1;
          end else if (!i_stall) begin
            ifid       <= wbuf;
            ifid_valid <= 1'b1;
            state      <= ST_FETCH;
            req_q      <= 1'b1;
          end
        end
`endif

        ST_DROP: begin
          if (imem.i_imem_ready) begin
            pc    <= i_redirect ? i_redirect_pc : target;
            state <= ST_FETCH;
          end else if (i_redirect) begin
            target <= i_redirect_pc;
          end
        end

        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage. Memory returns
// addr ^ 32'hA5A5_A5A5. A second instance with RESET_PC = 32'hFFFF_FFF8 and
// ready tied high exercises PC wrap-around.
module tb_if_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [31:0] pc_plus4, ifid_pc, ifid_pc4, ifid_instr;
  logic        ifid_valid;
  logic [31:0] w_pc_plus4, w_ifid_pc, w_ifid_pc4, w_ifid_instr;
  logic        w_ifid_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wrap_tab [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

  if_fetch_stage_if imem ();
  if_fetch_stage_if imem_w ();

  assign imem.i_imem_rdata     = imem.o_imem_addr ^ KEY;
  assign imem_w.i_imem_rdata   = imem_w.o_imem_addr ^ KEY;
  assign imem_w.i_imem_ready   = 1'b1;

  if_fetch_stage u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .imem          (imem.master),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_pc_plus4    (pc_plus4),
    .o_ifid_valid  (ifid_valid),
    .o_ifid_pc     (ifid_pc),
    .o_ifid_pc4    (ifid_pc4),
    .o_ifid_instr  (ifid_instr)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .imem          (imem_w.master),
    .i_stall       (1'b0),
    .i_redirect    (1'b0),
    .i_redirect_pc (32'h0),
    .o_pc_plus4    (w_pc_plus4),
    .o_ifid_valid  (w_ifid_valid),
    .o_ifid_pc     (w_ifid_pc),
    .o_ifid_pc4    (w_ifid_pc4),
    .o_ifid_instr  (w_ifid_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"},   32'(imem.o_imem_req), 32'h0);
    check({tag, "_valid"}, 32'(ifid_valid),      32'h0);
    check({tag, "_pc"},    ifid_pc,              32'h0);
    check({tag, "_pc4"},   ifid_pc4,             32'h0);
    check({tag, "_instr"}, ifid_instr,           32'h0);
    check({tag, "_addr"},  imem.o_imem_addr,     32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    stall             = 1'b0;
    redirect          = 1'b0;
    redirect_pc       = 32'h0;
    imem.i_imem_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    check_reset_state("rst");
    check("rst_pc_plus4", pc_plus4, 32'h4);

    // Back-to-back fetch with ready tied high; wrap instance alongside.
    rst_n             = 1'b1;
    imem.i_imem_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("seq_addr", imem.o_imem_addr, 32'(4 * k));
      check("seq_req", 32'(imem.o_imem_req), 32'h1);
      check("seq_pc_plus4", pc_plus4, 32'(4 * k + 4));
      if (k < 3) check("wrap_addr", imem_w.o_imem_addr, wrap_tab[k]);
      if (k == 1) check("wrap_pc_plus4", w_pc_plus4, 32'h0);
      if (k > 0) begin
        check("seq_valid", 32'(ifid_valid), 32'h1);
        check("seq_ifid_pc", ifid_pc, 32'(4 * (k - 1)));
        check("seq_ifid_pc4", ifid_pc4, 32'(4 * k));
        check("seq_instr", ifid_instr, 32'(4 * (k - 1)) ^ KEY);
      end
      @(negedge clk);
    end

    // Stall as pc 0x10 completes, held 4 cycles.
    stall = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      check("stall_req", 32'(imem.o_imem_req), 32'h0);
      check("stall_addr", imem.o_imem_addr, 32'h14);
      check("stall_valid", 32'(ifid_valid), 32'h1);
      check("stall_ifid_pc", ifid_pc, 32'hC);
      check("stall_instr", ifid_instr, 32'hC ^ KEY);
    end
    stall = 1'b0;
    @(negedge clk);
    check("unstall_ifid_pc", ifid_pc, 32'h10);
    check("unstall_ifid_pc4", ifid_pc4, 32'h14);
    check("unstall_instr", ifid_instr, 32'h10 ^ KEY);
    check("unstall_valid", 32'(ifid_valid), 32'h1);
    check("unstall_addr", imem.o_imem_addr, 32'h14);
    check("unstall_req", 32'(imem.o_imem_req), 32'h1);

    // Ready every third cycle.
    for (int j = 0; j < 3; j++) begin
      for (int c = 0; c < 3; c++) begin
        imem.i_imem_ready = (c == 2);
        check("slow_addr", imem.o_imem_addr, 32'(32'h14 + 4 * j));
        check("slow_valid", 32'(ifid_valid), (c == 0) ? 32'h1 : 32'h0);
        if (c == 0) check("slow_ifid_pc", ifid_pc, 32'(32'h10 + 4 * j));
        @(negedge clk);
      end
    end
    check("slow_end_addr", imem.o_imem_addr, 32'h20);
    check("slow_end_ifid_pc", ifid_pc, 32'h1C);

    // Redirect to 0x400 while 0x20 outstanding with ready low.
    imem.i_imem_ready = 1'b0;
    redirect          = 1'b1;
    redirect_pc       = 32'h400;
    @(negedge clk);
    redirect = 1'b0;
    check("drop_addr0", imem.o_imem_addr, 32'h20);
    check("drop_req", 32'(imem.o_imem_req), 32'h1);
    check("drop_valid", 32'(ifid_valid), 32'h0);
    @(negedge clk);
    check("drop_addr1", imem.o_imem_addr, 32'h20);
    imem.i_imem_ready = 1'b1;
    @(negedge clk);
    check("redir_addr", imem.o_imem_addr, 32'h400);
`ifdef IF_DELAY_SLOT_EN
    check("dslot_valid", 32'(ifid_valid), 32'h1);
    check("dslot_ifid_pc", ifid_pc, 32'h20);
`else
    check("flush_valid", 32'(ifid_valid), 32'h0);
`endif
    @(negedge clk);
    check("target_ifid_pc", ifid_pc, 32'h400);
    check("target_valid", 32'(ifid_valid), 32'h1);
    check("target_addr", imem.o_imem_addr, 32'h404);

    // Redirect with ready high: target on the bus next cycle.
    redirect    = 1'b1;
    redirect_pc = 32'h800;
    @(negedge clk);
    redirect = 1'b0;
    check("redir1_addr", imem.o_imem_addr, 32'h800);
`ifdef IF_DELAY_SLOT_EN
    check("dslot1_valid", 32'(ifid_valid), 32'h1);
    check("dslot1_ifid_pc", ifid_pc, 32'h404);
`else
    check("flush1_valid", 32'(ifid_valid), 32'h0);
`endif
    @(negedge clk);
    check("redir1_ifid_pc", ifid_pc, 32'h800);
    check("redir1_next_addr", imem.o_imem_addr, 32'h804);

    // Reset pulse while in BUF.
    stall = 1'b1;
    @(negedge clk);
    check("buf_req", 32'(imem.o_imem_req), 32'h0);
    rst_n = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    check("resume_req", 32'(imem.o_imem_req), 32'h1);
    check("resume_addr", imem.o_imem_addr, 32'h0);
    @(negedge clk);
    check("resume_ifid_pc", ifid_pc, 32'h0);
    check("resume_instr", ifid_instr, KEY);
    check("resume_valid", 32'(ifid_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the pipelined CPU. Holds the program counter and issues instruction-memory requests. Computes the sequential PC+4, which also feeds the downstream branch-target adder. Loads the IF/ID pipeline register, and handles hazard-unit stalls, branch/jump redirects, and multi-cycle instruction-memory latency.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- o_imem_req  out  1  fetch request; held high until accepted.
- o_imem_addr  out  32  fetch address (current PC), word-aligned.
- i_imem_ready  in  1  high in the cycle i_imem_rdata is valid; completes the request.
- i_imem_rdata  in  32  instruction word.
- i_stall  in  1  hazard unit: IF/ID must hold.
- i_redirect  in  1  branch/jump taken, from ID.
- i_redirect_pc  in  32  new fetch target.
- o_pc_plus4  out  32  combinational PC+4 of the current PC.
- o_ifid_valid  out  1  IF/ID holds a real instruction.
- o_ifid_pc  out  32  PC of the IF/ID instruction.
- o_ifid_pc4  out  32  PC+4 of the IF/ID instruction.
- o_ifid_instr  out  32  IF/ID instruction word.

## Operation
- States:
  - IDLE: after reset; no request.
  - FETCH: request outstanding.
  - BUF: fetched word parked in a 1-entry buffer during a stall.
  - DROP: waiting for an in-flight request whose result is discarded.
- IDLE -> FETCH unconditionally on the next cycle.
- FETCH, ready=1, stall=0:
  - IF/ID <= {1, pc, pc+4, rdata}.
  - pc <= pc+4.
  - Stay in FETCH; the request stays high, giving back-to-back fetch.
- FETCH, ready=1, stall=1: buffer <= {pc, pc+4, rdata}; pc <= pc+4; go to BUF; o_imem_req=0 while in BUF.
- BUF, stall=0: IF/ID <= buffer; go to FETCH.
- Redirect, FETCH with ready=1: fetched word is discarded; pc <= i_redirect_pc; stay in FETCH.
- Redirect, FETCH with ready=0:
  - target latched.
  - Go to DROP; o_imem_addr keeps the old address until ready.
  - On ready: word discarded, pc <= target, go to FETCH.
- Redirect in BUF: buffer is discarded; pc <= i_redirect_pc; go to FETCH.
- Redirect in DROP: target is overwritten; stay in DROP.
- Any redirect clears o_ifid_valid on the next edge unless stall holds IF/ID.
- Hazard unit never asserts i_redirect together with i_stall. If it does, redirect wins and stall is ignored for the PC.
- Arithmetic: PC+4 is modulo 2^32. 32'hFFFF_FFFC wraps to 0 with no flag.

## Timing
- Reset values:
  - pc = RESET_PC, state = IDLE.
  - o_imem_req = 0.
  - o_ifid_valid = 0.
  - o_ifid_pc, o_ifid_pc4 = 0.
  - o_ifid_instr = 32'h0000_0000 (NOP).
  - buffer cleared.
- Reset mid-operation: any outstanding request is abandoned. Memory must tolerate req dropping without ready.
- Latency: address presented and ready in cycle N -> o_ifid_* valid at N+1.
- Throughput: 1 instruction/cycle when ready is tied high.
- Redirect in cycle N (ready=1) -> o_imem_addr = target in cycle N+1.
- Stall holds every o_ifid_* bit-for-bit. At most one word is buffered; no fetch is issued while in BUF.

## Configuration
- IF_DELAY_SLOT_EN defined: MIPS branch delay slot.
  - A redirect does not discard the word completing in its cycle (FETCH ready=1), the buffered word (BUF), or the in-flight word (no DROP entry). That word is delivered to IF/ID normally, and pc then becomes the target.
  - o_ifid_valid is not cleared by redirect.
- Undefined: the discard/flush behaviour above, with no delay slot.

## Structure
- Package if_pkg:
  - state encoding typedef (IDLE, FETCH, BUF, DROP).
  - NOP constant 32'h0000_0000.
  - default RESET_PC constant.
  - PC increment constant 32'd4.
- One sub-module: pc_incr (32-bit PC + 4, combinational), instantiated once. Its output is driven to o_pc_plus4 and used as the next sequential PC.

## Test plan
- Reset, ready tied 1, memory returns addr^32'hA5A5_A5A5 -> addresses 0,4,8,… one per cycle; o_ifid_pc = addr one cycle later; o_ifid_instr matches.
- ready pulses every 3rd cycle -> o_imem_addr holds for 3 cycles; o_ifid_valid high 1 cycle in 3; no address skipped.
- stall asserted when pc=0x10 completes, held 4 cycles -> state BUF, req=0, IF/ID frozen; after release IF/ID shows pc 0x10, next addr 0x14.
- redirect to 0x400 while 0x20 outstanding with ready=0 -> addr stays 0x20 until ready; word dropped; next addr 0x400. With IF_DELAY_SLOT_EN: 0x20 is delivered, then 0x400.
- RESET_PC=32'hFFFF_FFF8, ready=1 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- i_rst_n low for 1 cycle during BUF -> all outputs at reset values; fetch resumes at RESET_PC two cycles later.
